eu_operand_fetch_ctrl: RTL
==========================

Name: eu_operand_fetch_ctrl

Overview:
Per-exec-unit operand fetch sequencer. It sits between the instruction queue head and the ALU. For each accepted instruction it fetches register operands from two shared ports: the unit's local result cache (one read port) and the foreign-EU interconnect (one request channel). It captures immediates directly, holds partially gathered operands until both are present, then presents the operand pair to the ALU with a valid/ready handshake. It also re-requests foreign operands whose responses time out.

Parameters:
DATA_W, 16, operand data width
ADDR_W, 8, operand address width (EU index + uid, opaque to this block)
TIMEOUT, 15, cycles to wait for a foreign response before re-issuing; must be at least 1

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
instr_valid_i  in  1  iqueue head valid
instr_ready_o  out  1  instruction accepted when valid&ready
op0_isreg_i  in  1  1=register operand, 0=immediate
op0_isforeign_i  in  1  1=fetch via foreign port, else local cache
op0_addr_i  in  ADDR_W  op0 register address
op0_imm_i  in  DATA_W  op0 immediate
op1_isreg_i, op1_isforeign_i, op1_addr_i, op1_imm_i  in  1/1/ADDR_W/DATA_W  same for op1
lreq_valid_o  out  1  local cache read request
lreq_addr_o  out  ADDR_W  local request address
lreq_ready_i  in  1  local request accepted
lrsp_valid_i  in  1  local read data valid
lrsp_data_i  in  DATA_W  local read data
freq_valid_o  out  1  foreign request
freq_addr_o  out  ADDR_W  foreign request address
freq_ready_i  in  1  foreign request accepted
frsp_valid_i  in  1  foreign response valid
frsp_data_i  in  DATA_W  foreign response data
alu_valid_o  out  1  operand pair valid
alu_op0_o  out  DATA_W  operand 0
alu_op1_o  out  DATA_W  operand 1
alu_ready_i  in  1  ALU accepts pair
retry_o  out  1  one-cycle pulse when a foreign request is re-issued

Behaviour:
- Reset: all outputs 0; state IDLE; pending flags, outstanding flags, tags, timer and operand registers cleared. Reset mid-operation drops everything in flight. Any response arriving afterwards finds no outstanding request and is ignored.
- States: IDLE, FETCH, ISSUE.
- instr_ready_o = (state==IDLE) | (state==ISSUE & alu_ready_i).
- On accept:
  - Immediate operands are latched into their operand registers.
  - Each register operand sets its pending flag and latches its address and isforeign bit.
  - If nothing is pending, the next state is ISSUE; otherwise FETCH.
- FETCH, local port:
  - lreq_valid_o = some local operand pending & not yet requested & no local request outstanding.
  - Address is op0's if op0 qualifies, else op1's (op0 has priority).
  - On lreq handshake: set local-outstanding and record a tag (0/1) naming the operand.
  - On lrsp_valid_i with local-outstanding: write lrsp_data_i to the tagged operand register, clear its pending flag, clear local-outstanding.
  - lrsp_valid_i with nothing outstanding is dropped.
- FETCH, foreign port: same rules on the freq/frsp signals, with its own outstanding flag and tag, and op0 priority. The local and foreign ports operate concurrently, so op0 local and op1 foreign may be in flight together.
- Request and response in the same cycle on the same port: a response completes the outstanding request first. A new request may handshake in the same cycle only if the port had no request outstanding at the start of the cycle, so at most one is outstanding per port.
- Foreign timeout:
  - The timer starts at 0 on each freq handshake and increments each cycle while outstanding with no response.
  - When it reaches TIMEOUT, clear foreign-outstanding (tag retained, pending stays set) and pulse retry_o. The request is re-issued by the normal rule.
  - A late response arriving after the retry, while the re-request is outstanding, is accepted as the answer. Same address, so same data.
- FETCH→ISSUE on the clock edge at which the last pending flag clears.
- ISSUE: alu_valid_o=1 and alu_op0_o/alu_op1_o are held stable until alu_ready_i.
  - On the handshake, a simultaneously accepted instruction proceeds as on accept from IDLE.
  - Otherwise the next state is IDLE.
- Latencies:
  - Both immediates: accept at cycle N, alu_valid_o at N+1.
  - One local operand with lreq_ready_i=1 and response one cycle later: lreq at N+1, lrsp at N+2, alu_valid_o at N+3.
- Both operands local: serialised through the local port, op0 first.

Test Plan:
- Both immediates, op0_imm=0x0012, op1_imm=0x0034, alu_ready=1 -> alu_valid_o at N+1 with 0x0012/0x0034; instr_ready_o high in the same cycle.
- op0 local addr 0x05 (returns 0xBEEF), op1 immediate 0x0001 -> lreq_addr_o=0x05 at N+1; alu_valid_o at N+3 with 0xBEEF/0x0001.
- Both operands local, addresses 0x03 and 0x04 -> requests issued in order 0x03 then 0x04, never overlapping; ALU receives the correct data for each operand.
- op0 foreign addr 0x81, op1 local addr 0x02, concurrent responses 0xAAAA/0x5555 -> both requests issued the cycle after accept; alu_op0_o=0xAAAA, alu_op1_o=0x5555.
- Foreign request with frsp withheld, TIMEOUT=4 -> retry_o pulses once 4 cycles after the handshake and freq_valid_o re-asserts with the same address; a response then completes the instruction.
- Reset asserted during FETCH with a local request outstanding, then a stray lrsp_valid_i -> all outputs 0 and state IDLE; the stray response is ignored; the next instruction completes correctly.

Source files
------------

// File: rtl/eu_operand_fetch_ctrl_if.sv
// rtl/eu_operand_fetch_ctrl_if.sv - operand fetch sequencer bus bundle
interface eu_operand_fetch_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  // instruction queue head
  logic              instr_valid_i;
  logic              instr_ready_o;
  logic              op0_isreg_i;
  logic              op0_isforeign_i;
  logic [ADDR_W-1:0] op0_addr_i;
  logic [DATA_W-1:0] op0_imm_i;
  logic              op1_isreg_i;
  logic              op1_isforeign_i;
  logic [ADDR_W-1:0] op1_addr_i;
  logic [DATA_W-1:0] op1_imm_i;
  // local result cache port
  logic              lreq_valid_o;
  logic [ADDR_W-1:0] lreq_addr_o;
  logic              lreq_ready_i;
  logic              lrsp_valid_i;
  logic [DATA_W-1:0] lrsp_data_i;
  // foreign-EU interconnect port
  logic              freq_valid_o;
  logic [ADDR_W-1:0] freq_addr_o;
  logic              freq_ready_i;
  logic              frsp_valid_i;
  logic [DATA_W-1:0] frsp_data_i;
  // ALU side
  logic              alu_valid_o;
  logic [DATA_W-1:0] alu_op0_o;
  logic [DATA_W-1:0] alu_op1_o;
  logic              alu_ready_i;
  logic              retry_o;

  // master: the fetch controller itself
  modport master (
    input  instr_valid_i, op0_isreg_i, op0_isforeign_i, op0_addr_i, op0_imm_i,
           op1_isreg_i, op1_isforeign_i, op1_addr_i, op1_imm_i,
           lreq_ready_i, lrsp_valid_i, lrsp_data_i,
           freq_ready_i, frsp_valid_i, frsp_data_i, alu_ready_i,
    output instr_ready_o, lreq_valid_o, lreq_addr_o, freq_valid_o, freq_addr_o,
           alu_valid_o, alu_op0_o, alu_op1_o, retry_o
  );

  // slave: queue, caches, interconnect and ALU around it
  modport slave (
    output instr_valid_i, op0_isreg_i, op0_isforeign_i, op0_addr_i, op0_imm_i,
           op1_isreg_i, op1_isforeign_i, op1_addr_i, op1_imm_i,
           lreq_ready_i, lrsp_valid_i, lrsp_data_i,
           freq_ready_i, frsp_valid_i, frsp_data_i, alu_ready_i,
    input  instr_ready_o, lreq_valid_o, lreq_addr_o, freq_valid_o, freq_addr_o,
           alu_valid_o, alu_op0_o, alu_op1_o, retry_o
  );
endinterface

// File: rtl/eu_operand_fetch_ctrl.sv
// rtl/eu_operand_fetch_ctrl.sv - per-EU operand fetch sequencer (local + foreign ports)
module eu_operand_fetch_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   reset_n,
  eu_operand_fetch_ctrl_if.master bus
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t            state, state_n;
  logic [1:0]        pend, isf;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] op0_q, op1_q;
  logic              l_out, l_tag, f_out, f_tag;
  logic [TW-1:0]     timer;

  logic       accept, l_any, f_any, l_sel, f_sel;
  logic       l_hs, f_hs, l_done, f_done, f_tmo;
  logic [1:0] pend_clr, pend_after;

  // port arbitration, handshakes and next state
  always_comb begin
    state_n  = state;
    pend_clr = 2'b00;
    l_any    = (pend[0] & ~isf[0]) | (pend[1] & ~isf[1]);
    f_any    = (pend[0] & isf[0]) | (pend[1] & isf[1]);
    // op0 wins whenever it still needs that port
    l_sel    = ~(pend[0] & ~isf[0]);
    f_sel    = ~(pend[0] & isf[0]);

    bus.lreq_valid_o = (state == FETCH) & l_any & ~l_out;
    bus.lreq_addr_o  = l_sel ? addr1 : addr0;
    bus.freq_valid_o = (state == FETCH) & f_any & ~f_out;
    bus.freq_addr_o  = f_sel ? addr1 : addr0;

    l_hs   = bus.lreq_valid_o & bus.lreq_ready_i;
    f_hs   = bus.freq_valid_o & bus.freq_ready_i;
    l_done = l_out & bus.lrsp_valid_i;
    f_done = f_out & bus.frsp_valid_i;
    // the cycle whose edge brings the timer up to TIMEOUT
    f_tmo  = f_out & ~bus.frsp_valid_i & (timer == TMO_LAST);
    bus.retry_o = f_tmo;

    if (l_done) pend_clr[l_tag] = 1'b1;
    if (f_done) pend_clr[f_tag] = 1'b1;
    pend_after = pend & ~pend_clr;

    bus.alu_valid_o   = (state == ISSUE);
    bus.alu_op0_o     = op0_q;
    bus.alu_op1_o     = op1_q;
    bus.instr_ready_o = reset_n & ((state == IDLE) | ((state == ISSUE) & bus.alu_ready_i));
    accept = bus.instr_valid_i & bus.instr_ready_o;

    case (state)
      IDLE:    if (accept) state_n = (bus.op0_isreg_i | bus.op1_isreg_i) ? FETCH : ISSUE;
      FETCH:   if (pend_after == 2'b00) state_n = ISSUE;
      ISSUE: begin
        if (bus.alu_ready_i) begin
          if (accept) state_n = (bus.op0_isreg_i | bus.op1_isreg_i) ? FETCH : ISSUE;
          else        state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state, operand capture, outstanding tracking and timeout timer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      pend  <= 2'b00;
      isf   <= 2'b00;
      addr0 <= '0;
      addr1 <= '0;
      op0_q <= '0;
      op1_q <= '0;
      l_out <= 1'b0;
      l_tag <= 1'b0;
      f_out <= 1'b0;
      f_tag <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        pend  <= {bus.op1_isreg_i, bus.op0_isreg_i};
        isf   <= {bus.op1_isforeign_i, bus.op0_isforeign_i};
        addr0 <= bus.op0_addr_i;
        addr1 <= bus.op1_addr_i;
        if (!bus.op0_isreg_i) op0_q <= bus.op0_imm_i;
        if (!bus.op1_isreg_i) op1_q <= bus.op1_imm_i;
      end else begin
        pend <= pend_after;
      end

      if (l_done) begin
        l_out <= 1'b0;
        if (l_tag) op1_q <= bus.lrsp_data_i;
        else       op0_q <= bus.lrsp_data_i;
      end else if (l_hs) begin
        l_out <= 1'b1;
        l_tag <= l_sel;
      end

      // a timed-out operand keeps its tag and pending bit; the normal rule re-requests it
      if (f_done) begin
        f_out <= 1'b0;
        if (f_tag) op1_q <= bus.frsp_data_i;
        else       op0_q <= bus.frsp_data_i;
      end else if (f_tmo) begin
        f_out <= 1'b0;
      end else if (f_hs) begin
        f_out <= 1'b1;
        f_tag <= f_sel;
        timer <= '0;
      end else if (f_out) begin
        timer <= timer + 1'b1;
      end
    end
  end
endmodule
